// File: rtl/card_reader_pkg.sv
// Shared types and constants for the card_reader badge front end.
// Holds the authorised-ID table, the receive FSM states and the table lookup helper.
package card_reader_pkg;

  localparam int AUTH_COUNT = 4;

  localparam logic [15:0] AUTH_IDS [0:AUTH_COUNT-1] = '{
    16'hA5C3, 16'h1234, 16'hBEEF, 16'h0F0F
  };

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    CHECK
  } rx_state_t;

  // Callers zero-extend their ID so the table works for any ID_WIDTH up to 32
  function automatic logic id_in_table(input logic [31:0] id);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < AUTH_COUNT; i++) begin
      if (id == {16'h0000, AUTH_IDS[i]}) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/card_rx_deser.sv
// Serial frame receiver: 2-flop synchroniser, mid-bit sampler and LSB-first shift register.
// Even-parity bit is received and checked only when CARD_READER_PARITY_EN is defined.
module card_rx_deser
  import card_reader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int ID_WIDTH     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                card_rx,
  output logic [ID_WIDTH-1:0] data,
  output logic                stop_ok,
  output logic                parity_ok,
  output logic                done,
  output logic                busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(ID_WIDTH + 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(ID_WIDTH - 1);

  logic          rx_meta;
  logic          rx_sync;
  logic          rx_prev;
  rx_state_t     state;
  logic [TW-1:0] timer;
  logic [BW-1:0] bit_idx;

  // Flops reset high so a reset never looks like a start edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= card_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      bit_idx   <= '0;
      data      <= '0;
      stop_ok   <= 1'b0;
      parity_ok <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_sync && rx_prev) begin
            state <= START;
            timer <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (timer == HALF_LAST) begin
            timer   <= '0;
            bit_idx <= '0;
            if (!rx_sync) begin
              state <= DATA;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DATA: begin
          if (timer == BIT_LAST) begin
            timer <= '0;
            data  <= {rx_sync, data[ID_WIDTH-1:1]};
            if (bit_idx == LAST_BIT) begin
              bit_idx <= '0;
`ifdef CARD_READER_PARITY_EN
              state   <= PARITY;
`else
              state   <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
`ifdef CARD_READER_PARITY_EN
        PARITY: begin
          if (timer == BIT_LAST) begin
            timer     <= '0;
            parity_ok <= ~(^data ^ rx_sync);
            state     <= STOP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
`endif
        STOP: begin
          if (timer == BIT_LAST) begin
            timer   <= '0;
            stop_ok <= rx_sync;
`ifndef CARD_READER_PARITY_EN
            parity_ok <= 1'b1;
`endif
            state   <= CHECK;
            done    <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        CHECK: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/card_reader.sv
// Badge reader top: validates received frames against the authorised table and drives
// the card_valid hold level / card_invalid pulse. Parity option: CARD_READER_PARITY_EN.
module card_reader
  import card_reader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int ID_WIDTH     = 16,
  parameter int HOLD_CYCLES  = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                card_rx,
  output logic                card_valid,
  output logic                card_invalid,
  output logic [ID_WIDTH-1:0] card_id,
  output logic                busy
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);

  logic [ID_WIDTH-1:0] rx_data;
  logic                stop_ok;
  logic                parity_ok;
  logic                frame_done;
  logic                accept;
  logic [HW-1:0]       hold_cnt;

  card_rx_deser #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .ID_WIDTH    (ID_WIDTH)
  ) u_deser (
    .clk      (clk),
    .reset    (reset),
    .card_rx  (card_rx),
    .data     (rx_data),
    .stop_ok  (stop_ok),
    .parity_ok(parity_ok),
    .done     (frame_done),
    .busy     (busy)
  );

  // All-zero and all-one IDs come from a stuck line and are never trusted
  assign accept = stop_ok && parity_ok && id_in_table(32'(rx_data))
                  && (rx_data != '0) && (rx_data != '1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt     <= '0;
      card_invalid <= 1'b0;
      card_id      <= '0;
    end else begin
      card_invalid <= frame_done && !accept;
      if (frame_done) card_id <= rx_data;
      if (frame_done && accept) begin
        hold_cnt <= HW'(HOLD_CYCLES);
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
    end
  end

  assign card_valid = (hold_cnt != '0);

endmodule

// File: tb/tb_card_reader.sv
// Self-checking bench for card_reader: directed frame table, corner sequences and random frames.
// A second instance with a long hold exposes the hold-reload behaviour on back-to-back frames.
module tb_card_reader;

  localparam int C         = 16;
  localparam int ID_W      = 16;
  localparam int HOLD      = 20;
  localparam int HOLD_LONG = 400;
`ifdef CARD_READER_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif
  localparam int NB   = ID_W + PAR_EN;
  localparam int LAT  = 3 + C / 2 + (NB + 1) * C + 1;
  localparam int MAXC = 20000;
  localparam logic [15:0] BENCH_AUTH [4] = '{16'hA5C3, 16'h1234, 16'hBEEF, 16'h0F0F};

  typedef struct {
    logic [15:0] id;
    bit          stop_bit;
    bit          bad_par;
    int          gap;
    bit          exp_accept;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        card_rx;
  logic        card_valid;
  logic        card_invalid;
  logic [15:0] card_id;
  logic        busy;
  logic        long_valid;
  logic        long_invalid;
  logic [15:0] long_id;
  logic        long_busy;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  bit          exp_busy       [MAXC];
  bit          exp_valid      [MAXC];
  bit          exp_valid_long [MAXC];
  bit          exp_invalid    [MAXC];
  bit          exp_id_en      [MAXC];
  logic [15:0] exp_id         [MAXC];

  card_reader #(.CLKS_PER_BIT(C), .ID_WIDTH(ID_W), .HOLD_CYCLES(HOLD)) dut (
    .clk         (clk),
    .reset       (reset),
    .card_rx     (card_rx),
    .card_valid  (card_valid),
    .card_invalid(card_invalid),
    .card_id     (card_id),
    .busy        (busy)
  );

  card_reader #(.CLKS_PER_BIT(C), .ID_WIDTH(ID_W), .HOLD_CYCLES(HOLD_LONG)) dut_long (
    .clk         (clk),
    .reset       (reset),
    .card_rx     (card_rx),
    .card_valid  (long_valid),
    .card_invalid(long_invalid),
    .card_id     (long_id),
    .busy        (long_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                  name, actual, expected, cyc);
  endtask

  function automatic bit modelAccept(input logic [15:0] id, input bit stop_bit,
                                     input bit bad_par);
    bit known;
    known = 1'b0;
    for (int i = 0; i < 4; i++) if (id == BENCH_AUTH[i]) known = 1'b1;
    return known && stop_bit && !(PAR_EN == 1 && bad_par)
           && id != 16'h0000 && id != 16'hFFFF;
  endfunction

  // Must be called right after a negedge; records the expected outputs, then drives the frame
  task automatic applyStimulus(input logic [15:0] id, input bit stop_bit, input bit bad_par,
                               input int gap, input bit exp_accept);
    int c0;
    int e;
    c0 = cyc;
    e  = c0 + LAT;
    for (int n = c0 + 3; n < e; n++) if (n < MAXC) exp_busy[n] = 1'b1;
    if (exp_accept) begin
      for (int n = e; n < e + HOLD; n++) if (n < MAXC) exp_valid[n] = 1'b1;
      for (int n = e; n < e + HOLD_LONG; n++) if (n < MAXC) exp_valid_long[n] = 1'b1;
    end else if (e < MAXC) begin
      exp_invalid[e] = 1'b1;
    end
    if (e < MAXC) begin
      exp_id_en[e] = 1'b1;
      exp_id[e]    = id;
    end
    card_rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < ID_W; i++) begin
      card_rx = id[i];
      repeat (C) @(negedge clk);
    end
    if (PAR_EN == 1) begin
      card_rx = (^id) ^ bad_par;
      repeat (C) @(negedge clk);
    end
    card_rx = stop_bit;
    repeat (C) @(negedge clk);
    card_rx = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  // Per-cycle comparison against the expectation arrays, sampled after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (cyc < MAXC) begin
        checkOutput("busy", 32'(busy), 32'(exp_busy[cyc]));
        checkOutput("card_valid", 32'(card_valid), 32'(exp_valid[cyc]));
        checkOutput("card_invalid", 32'(card_invalid), 32'(exp_invalid[cyc]));
        checkOutput("long_valid", 32'(long_valid), 32'(exp_valid_long[cyc]));
        checkOutput("long_invalid", 32'(long_invalid), 32'(exp_invalid[cyc]));
        checkOutput("long_busy", 32'(long_busy), 32'(exp_busy[cyc]));
        if (exp_id_en[cyc]) begin
          checkOutput("card_id", 32'(card_id), 32'(exp_id[cyc]));
          checkOutput("long_id", 32'(long_id), 32'(exp_id[cyc]));
        end
      end
    end
  end

  initial begin
    vec_t vecs[10];
    int   c0;
    int   hi;

    vecs[0] = '{16'hA5C3, 1'b1, 1'b0, 5, 1'b1};
    vecs[1] = '{16'h5555, 1'b1, 1'b0, 5, 1'b0};
    vecs[2] = '{16'h1234, 1'b0, 1'b0, 5, 1'b0};
    vecs[3] = '{16'h1234, 1'b1, 1'b1, 5, bit'(PAR_EN == 0)};
    vecs[4] = '{16'hBEEF, 1'b1, 1'b0, 0, 1'b1};
    vecs[5] = '{16'hBEEF, 1'b1, 1'b0, 5, 1'b1};
    vecs[6] = '{16'h0000, 1'b1, 1'b0, 5, 1'b0};
    vecs[7] = '{16'hFFFF, 1'b1, 1'b0, 5, 1'b0};
    vecs[8] = '{16'h0F0F, 1'b1, 1'b0, 5, 1'b1};
    vecs[9] = '{16'h1234, 1'b1, 1'b0, 5, 1'b1};

    reset   = 1'b1;
    card_rx = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("reset_card_id", 32'(card_id), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] reset in the middle of a frame");
    c0 = cyc;
    for (int n = c0 + 3; n <= c0 + 100; n++) exp_busy[n] = 1'b1;
    for (int k = 0; k < 100; k++) begin
      card_rx = (k < C) ? 1'b0 : vecs[0].id[(k - C) / C];
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    checkOutput("midframe_reset_busy", 32'(busy), 32'h0);
    checkOutput("midframe_reset_invalid", 32'(card_invalid), 32'h0);
    checkOutput("midframe_reset_valid", 32'(card_valid), 32'h0);
    card_rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    $display("[TB] 3-cycle glitch on idle line");
    c0 = cyc;
    for (int n = c0 + 3; n <= c0 + 3 + C / 2 - 1; n++) exp_busy[n] = 1'b1;
    hi = 0;
    for (int k = 0; k < 28; k++) begin
      card_rx = (k < 3) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (busy) hi++;
    end
    checkOutput("glitch_busy_seen", 32'(hi > 0), 32'h1);
    checkOutput("glitch_busy_short", 32'(hi <= C / 2 + 1), 32'h1);

    $display("[TB] directed frame table");
    for (int v = 0; v < 10; v++) begin
      applyStimulus(vecs[v].id, vecs[v].stop_bit, vecs[v].bad_par, vecs[v].gap,
                    vecs[v].exp_accept);
    end

    $display("[TB] random frames");
    for (int r = 0; r < 20; r++) begin
      logic [15:0] id;
      bit          sb;
      bit          bp;
      int          g;
      if ($urandom_range(0, 1) == 1) id = BENCH_AUTH[$urandom_range(0, 3)];
      else id = 16'($urandom);
      sb = ($urandom_range(0, 9) != 0);
      bp = ($urandom_range(0, 9) == 0);
      g  = sb ? int'($urandom_range(0, 30)) : int'($urandom_range(3, 30));
      applyStimulus(id, sb, bp, g, modelAccept(id, sb, bp));
    end

    repeat (HOLD_LONG + 20) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
